// File: rtl/axi4_burst_checker_pkg.sv
// Shared definitions for the AXI4 burst-integrity monitor.
//  - err_idx_e : bit positions inside err_vec
//  - ERR_W     : width of err_vec
//  - ch_err_t  : per-direction error bundle produced by the channel logic
package axi4_chk_pkg;

    localparam int ERR_W = 11;

    typedef enum int unsigned {
        E_WLAST_EARLY = 0,
        E_WLAST_MISS  = 1,
        E_W_NO_ADDR   = 2,
        E_B_NO_DATA   = 3,
        E_AW_OVF      = 4,
        E_WR_TIMEOUT  = 5,
        E_RLAST_EARLY = 6,
        E_RLAST_MISS  = 7,
        E_R_NO_ADDR   = 8,
        E_AR_OVF      = 9,
        E_RD_TIMEOUT  = 10
    } err_idx_e;

    // Errors detected on one direction in the current cycle.
    typedef struct packed {
        logic early;    // LAST before AxLEN+1 beats
        logic miss;     // AxLEN+1 beats seen without LAST
        logic no_addr;  // data beat with no outstanding address
        logic ovf;      // address accepted while length FIFO full
        logic timeout;  // watchdog expired
    } ch_err_t;

endpackage

// File: rtl/axi4_burst_checker_len_fifo.sv
// Synchronous FIFO holding AxLEN values of outstanding bursts.
// Ports:
//  sys_clk, sys_rstn : clock, synchronous active-low reset
//  push, din         : write an entry (ignored while full)
//  pop               : drop the head entry (ignored while empty)
//  full, empty       : occupancy flags
//  head              : oldest entry, valid while !empty
module axi4_len_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         sys_clk,
    input  logic         sys_rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = (cnt == CNT_MAX);
    assign empty   = (cnt == '0);
    assign head    = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= (wptr == PTR_MAX) ? '0 : wptr + 1'b1;
            if (do_pop)  rptr <= (rptr == PTR_MAX) ? '0 : rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind the count.
    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/axi4_burst_checker.sv
// Passive AXI4 burst-integrity monitor. Nothing is driven onto the bus.
// Tracks up to MAX_OUT outstanding bursts per direction and flags beat-count /
// LAST mismatches, orphan data beats, orphan B responses, address overflow
// and stalls (separate write/read watchdogs).
// Ports:
//  sys_clk, sys_rstn        : clock, synchronous active-low reset
//  aw*/w*/b*                : write address / data / response tap
//  ar*/r*                   : read address / data tap
//  err_clr                  : clears err_vec (a same-cycle new error wins)
//  err_vec                  : sticky error flags, bit map in axi4_chk_pkg
//  err_pulse                : one cycle when any err_vec bit goes 0->1
//  wr_done_cnt, rd_done_cnt : completed burst counters, wrapping
module axi4_burst_checker
    import axi4_chk_pkg::*;
#(
    parameter int LSIZE   = 8,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 100,
    parameter int CSIZE   = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic             awvalid,
    input  logic             awready,
    input  logic [LSIZE-1:0] awlen,
    input  logic             wvalid,
    input  logic             wready,
    input  logic             wlast,
    input  logic             bvalid,
    input  logic             bready,
    input  logic             arvalid,
    input  logic             arready,
    input  logic [LSIZE-1:0] arlen,
    input  logic             rvalid,
    input  logic             rready,
    input  logic             rlast,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_vec,
    output logic             err_pulse,
    output logic [CSIZE-1:0] wr_done_cnt,
    output logic [CSIZE-1:0] rd_done_cnt
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // ---------------- handshakes ----------------
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid  & wready;
    assign b_hs  = bvalid  & bready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid  & rready;

    // ---------------- write direction ----------------
    logic             wf_push, wf_pop, wf_full, wf_empty;
    logic [LSIZE-1:0] wf_head, w_len, wcnt;
    logic             w_bind, w_byp, w_at_len, w_close, b_ok;
    logic [CSIZE-1:0] pend_b;
    logic [WD_W-1:0]  wr_wd;
    logic             wr_busy, wr_prog, wr_tmo;
    ch_err_t          werr;

    axi4_len_fifo #(.W(LSIZE), .DEPTH(MAX_OUT)) u_wfifo (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .push     (wf_push),
        .din      (awlen),
        .pop      (wf_pop),
        .full     (wf_full),
        .empty    (wf_empty),
        .head     (wf_head)
    );

    // A beat arriving with an empty FIFO binds to a same-cycle AW (bypass).
    assign w_bind   = w_hs & (~wf_empty | aw_hs);
    assign w_byp    = w_bind & wf_empty;
    assign w_len    = wf_empty ? awlen : wf_head;
    assign w_at_len = (wcnt == w_len);
    assign w_close  = w_bind & (wlast | w_at_len);
    // A bypassed burst that closes on its only beat never enters the FIFO.
    assign wf_push  = aw_hs & ~wf_full & ~(w_byp & w_close);
    assign wf_pop   = w_close & ~wf_empty;
    // B alongside the closing beat is legal: the closing burst counts as pending.
    assign b_ok     = b_hs & ((pend_b != '0) | w_close);
    assign wr_busy  = ~wf_empty | (pend_b != '0);
    assign wr_prog  = aw_hs | w_hs | b_hs;
    assign wr_tmo   = wr_busy & ~wr_prog & (wr_wd == WD_LAST);

    always_comb begin
        werr         = '0;
        werr.early   = w_bind & wlast & ~w_at_len;
        werr.miss    = w_bind & w_at_len & ~wlast;
        werr.no_addr = w_hs & ~w_bind;
        werr.ovf     = aw_hs & wf_full;
        werr.timeout = wr_tmo;
    end

    // ---------------- read direction ----------------
    logic             rf_push, rf_pop, rf_full, rf_empty;
    logic [LSIZE-1:0] rf_head, r_len, rcnt;
    logic             r_bind, r_byp, r_at_len, r_close;
    logic [WD_W-1:0]  rd_wd;
    logic             rd_busy, rd_prog, rd_tmo;
    ch_err_t          rerr;

    axi4_len_fifo #(.W(LSIZE), .DEPTH(MAX_OUT)) u_rfifo (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .push     (rf_push),
        .din      (arlen),
        .pop      (rf_pop),
        .full     (rf_full),
        .empty    (rf_empty),
        .head     (rf_head)
    );

    assign r_bind   = r_hs & (~rf_empty | ar_hs);
    assign r_byp    = r_bind & rf_empty;
    assign r_len    = rf_empty ? arlen : rf_head;
    assign r_at_len = (rcnt == r_len);
    assign r_close  = r_bind & (rlast | r_at_len);
    assign rf_push  = ar_hs & ~rf_full & ~(r_byp & r_close);
    assign rf_pop   = r_close & ~rf_empty;
    assign rd_busy  = ~rf_empty;
    assign rd_prog  = ar_hs | r_hs;
    assign rd_tmo   = rd_busy & ~rd_prog & (rd_wd == WD_LAST);

    always_comb begin
        rerr         = '0;
        rerr.early   = r_bind & rlast & ~r_at_len;
        rerr.miss    = r_bind & r_at_len & ~rlast;
        rerr.no_addr = r_hs & ~r_bind;
        rerr.ovf     = ar_hs & rf_full;
        rerr.timeout = rd_tmo;
    end

    // ---------------- error collection ----------------
    logic [ERR_W-1:0] new_err, err_nxt;

    always_comb begin
        new_err                = '0;
        new_err[E_WLAST_EARLY] = werr.early;
        new_err[E_WLAST_MISS]  = werr.miss;
        new_err[E_W_NO_ADDR]   = werr.no_addr;
        new_err[E_B_NO_DATA]   = b_hs & ~b_ok;
        new_err[E_AW_OVF]      = werr.ovf;
        new_err[E_WR_TIMEOUT]  = werr.timeout;
        new_err[E_RLAST_EARLY] = rerr.early;
        new_err[E_RLAST_MISS]  = rerr.miss;
        new_err[E_R_NO_ADDR]   = rerr.no_addr;
        new_err[E_AR_OVF]      = rerr.ovf;
        new_err[E_RD_TIMEOUT]  = rerr.timeout;
    end

    // Clear applies first so a same-cycle detection keeps its bit.
    assign err_nxt = (err_clr ? '0 : err_vec) | new_err;

    // ---------------- state ----------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            wcnt        <= '0;
            rcnt        <= '0;
            pend_b      <= '0;
            wr_wd       <= '0;
            rd_wd       <= '0;
            err_vec     <= '0;
            err_pulse   <= 1'b0;
            wr_done_cnt <= '0;
            rd_done_cnt <= '0;
        end else begin
            if (w_close)     wcnt <= '0;
            else if (w_bind) wcnt <= wcnt + 1'b1;

            if (r_close)     rcnt <= '0;
            else if (r_bind) rcnt <= rcnt + 1'b1;

            case ({w_close, b_ok})
                2'b10:   pend_b <= pend_b + 1'b1;
                2'b01:   pend_b <= pend_b - 1'b1;
                default: pend_b <= pend_b;
            endcase

            if (!wr_busy || wr_prog || wr_tmo) wr_wd <= '0;
            else                               wr_wd <= wr_wd + 1'b1;

            if (!rd_busy || rd_prog || rd_tmo) rd_wd <= '0;
            else                               rd_wd <= rd_wd + 1'b1;

            if (b_ok)    wr_done_cnt <= wr_done_cnt + 1'b1;
            if (r_close) rd_done_cnt <= rd_done_cnt + 1'b1;

            err_vec   <= err_nxt;
            err_pulse <= |(new_err & ~err_vec);
        end
    end

endmodule

// File: tb/tb_axi4_burst_checker.sv
module tb_axi4_burst_checker;
    import axi4_chk_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        awvalid = 0, awready = 0, wvalid = 0, wready = 0, wlast = 0;
    logic        bvalid = 0, bready = 0, arvalid = 0, arready = 0;
    logic        rvalid = 0, rready = 0, rlast = 0, err_clr = 0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [10:0] err_vec;
    logic        err_pulse;
    logic [15:0] wr_done_cnt, rd_done_cnt;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    axi4_burst_checker #(.LSIZE(8), .MAX_OUT(4), .TIMEOUT(100), .CSIZE(16)) dut (
        .sys_clk     (sys_clk),
        .sys_rstn    (sys_rstn),
        .awvalid     (awvalid),
        .awready     (awready),
        .awlen       (awlen),
        .wvalid      (wvalid),
        .wready      (wready),
        .wlast       (wlast),
        .bvalid      (bvalid),
        .bready      (bready),
        .arvalid     (arvalid),
        .arready     (arready),
        .arlen       (arlen),
        .rvalid      (rvalid),
        .rready      (rready),
        .rlast       (rlast),
        .err_clr     (err_clr),
        .err_vec     (err_vec),
        .err_pulse   (err_pulse),
        .wr_done_cnt (wr_done_cnt),
        .rd_done_cnt (rd_done_cnt)
    );

    typedef struct packed {
        logic        stall;   // valids as given, all readies low
        logic        aw;
        logic [7:0]  awlen;
        logic        w;
        logic        wl;
        logic        b;
        logic        ar;
        logic [7:0]  arlen;
        logic        r;
        logic        rl;
        logic        clr;
        logic [10:0] e_err;
        logic        e_pulse;
        logic [15:0] e_wr;
        logic [15:0] e_rd;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic aw, input logic [7:0] al,
                         input logic w, input logic wl, input logic b,
                         input logic ar, input logic [7:0] rlen,
                         input logic r, input logic rl, input logic clr);
        awvalid = aw; awready = aw & ~stall; awlen = al;
        wvalid  = w;  wready  = w & ~stall;  wlast = wl;
        bvalid  = b;  bready  = b & ~stall;
        arvalid = ar; arready = ar & ~stall; arlen = rlen;
        rvalid  = r;  rready  = r & ~stall;  rlast = rl;
        err_clr = clr;
    endtask

    task automatic idle();
        drive(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        sys_rstn = 1'b0;
        step();
        step();
        sys_rstn = 1'b1;
    endtask

    initial begin
        int pulses;
        int k;
        bit seen;

        //             stall aw awlen w wl b ar arlen r rl clr  err      pulse wr  rd
        vecs[0]  = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h000,1'b0,16'd0,16'd0};
        vecs[1]  = '{1'b0,1'b1,8'd1,1'b0,1'b0,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h000,1'b0,16'd0,16'd0};
        vecs[2]  = '{1'b0,1'b0,8'd0,1'b1,1'b0,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h000,1'b0,16'd0,16'd0};
        vecs[3]  = '{1'b0,1'b0,8'd0,1'b1,1'b1,1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h000,1'b0,16'd1,16'd0};
        vecs[4]  = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h008,1'b1,16'd1,16'd0};
        vecs[5]  = '{1'b1,1'b0,8'd0,1'b1,1'b0,1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h008,1'b0,16'd1,16'd0};
        vecs[6]  = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b0,1'b0,8'd0,1'b0,1'b0,1'b1, 11'h000,1'b0,16'd1,16'd0};
        vecs[7]  = '{1'b0,1'b1,8'd0,1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h000,1'b0,16'd1,16'd0};
        vecs[8]  = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h000,1'b0,16'd2,16'd0};
        vecs[9]  = '{1'b0,1'b0,8'd0,1'b1,1'b0,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h004,1'b1,16'd2,16'd0};
        vecs[10] = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b0,1'b1,8'd0,1'b1,1'b0,1'b0, 11'h084,1'b1,16'd2,16'd1};
        vecs[11] = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b0,1'b1,8'd2,1'b0,1'b0,1'b0, 11'h084,1'b0,16'd2,16'd1};
        vecs[12] = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b0,1'b0,8'd0,1'b1,1'b1,1'b0, 11'h0C4,1'b1,16'd2,16'd2};
        vecs[13] = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b0,1'b0,8'd0,1'b1,1'b0,1'b0, 11'h1C4,1'b1,16'd2,16'd2};
        vecs[14] = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b1,1'b0,8'd0,1'b0,1'b0,1'b1, 11'h008,1'b1,16'd2,16'd2};
        vecs[15] = '{1'b0,1'b0,8'd0,1'b0,1'b0,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 11'h008,1'b0,16'd2,16'd2};

        // ---- reset state ----
        do_reset();
        chk("reset err_vec", int'(err_vec), 0);
        chk("reset err_pulse", int'(err_pulse), 0);
        chk("reset wr_done", int'(wr_done_cnt), 0);
        chk("reset rd_done", int'(rd_done_cnt), 0);

        // ---- table-driven single-cycle vectors ----
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].stall, vecs[i].aw, vecs[i].awlen, vecs[i].w, vecs[i].wl, vecs[i].b,
                  vecs[i].ar, vecs[i].arlen, vecs[i].r, vecs[i].rl, vecs[i].clr);
            step();
            chk($sformatf("vec%0d err_vec", i), int'(err_vec), int'(vecs[i].e_err));
            chk($sformatf("vec%0d err_pulse", i), int'(err_pulse), int'(vecs[i].e_pulse));
            chk($sformatf("vec%0d wr_done", i), int'(wr_done_cnt), int'(vecs[i].e_wr));
            chk($sformatf("vec%0d rd_done", i), int'(rd_done_cnt), int'(vecs[i].e_rd));
        end
        idle();

        // ---- good write burst: len 9, 10 beats, B ----
        do_reset();
        drive(0, 1, 8'd9, 0, 0, 0, 0, 8'd0, 0, 0, 0); step();
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 8'd0, 1, (i == 10), 0, 0, 8'd0, 0, 0, 0); step();
        end
        drive(0, 0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, 0); step();
        idle();
        chk("good_wr err_vec", int'(err_vec), 0);
        chk("good_wr wr_done", int'(wr_done_cnt), 1);

        // ---- early wlast: len 9, wlast on beat 5 ----
        do_reset();
        pulses = 0;
        drive(0, 1, 8'd9, 0, 0, 0, 0, 8'd0, 0, 0, 0); step();
        pulses += int'(err_pulse);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 8'd0, 1, (i == 5), 0, 0, 8'd0, 0, 0, 0); step();
            pulses += int'(err_pulse);
        end
        drive(0, 0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, 0); step();
        pulses += int'(err_pulse);
        idle(); step();
        pulses += int'(err_pulse);
        chk("early err_vec", int'(err_vec), 32'h001);
        chk("early pulses", pulses, 1);
        chk("early wr_done", int'(wr_done_cnt), 1);

        // ---- missing wlast: len 9, 20 beats ----
        do_reset();
        drive(0, 1, 8'd9, 0, 0, 0, 0, 8'd0, 0, 0, 0); step();
        for (int i = 1; i <= 20; i++) begin
            drive(0, 0, 8'd0, 1, 0, 0, 0, 8'd0, 0, 0, 0); step();
            if (i == 9)  chk("miss beat9 err_vec", int'(err_vec), 0);
            if (i == 10) chk("miss beat10 err_vec", int'(err_vec), 32'h002);
            if (i == 11) chk("miss beat11 err_vec", int'(err_vec), 32'h006);
        end
        idle();
        chk("miss final err_vec", int'(err_vec), 32'h006);
        chk("miss wr_done", int'(wr_done_cnt), 0);

        // ---- write timeout: AW only ----
        do_reset();
        drive(0, 1, 8'd1, 0, 0, 0, 0, 8'd0, 0, 0, 0); step();
        idle();
        k = 0;
        seen = 0;
        while (k < 200 && !seen) begin
            step();
            k++;
            if (err_vec[E_WR_TIMEOUT]) seen = 1;
        end
        chk("wr_timeout seen", int'(seen), 1);
        chk("wr_timeout latency", k, 100);
        chk("wr_timeout err_vec", int'(err_vec), 32'h020);
        chk("wr_timeout pulse", int'(err_pulse), 1);

        // ---- read: len 99, 120 beats, rlast on 120th ----
        do_reset();
        drive(0, 0, 8'd0, 0, 0, 0, 1, 8'd99, 0, 0, 0); step();
        for (int i = 1; i <= 120; i++) begin
            drive(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 1, (i == 120), 0); step();
            if (i == 100) chk("rd beat100 err_vec", int'(err_vec), 32'h080);
        end
        idle();
        chk("rd long err_vec", int'(err_vec), 32'h180);
        chk("rd long rd_done", int'(rd_done_cnt), 1);

        // ---- AW overflow, clear vs new error, reset mid-burst ----
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 8'd3, 0, 0, 0, 0, 8'd0, 0, 0, 0); step();
            if (i == 4) chk("ovf aw4 err_vec", int'(err_vec), 0);
        end
        chk("ovf aw5 err_vec", int'(err_vec), 32'h010);
        chk("ovf aw5 pulse", int'(err_pulse), 1);
        drive(0, 1, 8'd3, 0, 0, 0, 0, 8'd0, 0, 0, 1); step();
        chk("clr+ovf err_vec", int'(err_vec), 32'h010);
        drive(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 1); step();
        chk("clr only err_vec", int'(err_vec), 0);
        // open a write burst and a completed read, then reset in the middle
        drive(0, 0, 8'd0, 1, 0, 0, 1, 8'd0, 1, 1, 0); step();
        chk("pre-reset rd_done", int'(rd_done_cnt), 1);
        drive(0, 0, 8'd0, 1, 0, 0, 0, 8'd0, 0, 0, 0);
        sys_rstn = 1'b0;
        step();
        chk("midreset err_vec", int'(err_vec), 0);
        chk("midreset pulse", int'(err_pulse), 0);
        chk("midreset rd_done", int'(rd_done_cnt), 0);
        sys_rstn = 1'b1;
        // FIFO contents were discarded: a lone W is now an orphan
        drive(0, 0, 8'd0, 1, 0, 0, 0, 8'd0, 0, 0, 0); step();
        idle();
        chk("post-reset orphan err_vec", int'(err_vec), 32'h004);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
